// File: rtl/sm4_result_serializer.sv
// Buffers 128-bit SM4 result blocks in a small FIFO and streams each one out
// as four big-endian 32-bit words on a valid/ready interface.
module sm4_result_serializer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       sm4_enable_in,
  input  logic                       blk_valid_in,
  input  logic [127:0]               blk_data_in,
  input  logic                       word_ready_in,
  output logic                       word_valid_out,
  output logic [31:0]                word_data_out,
  output logic                       word_last_out,
  output logic [$clog2(DEPTH):0]     fifo_count_out,
  output logic                       full_out,
  output logic                       empty_out,
  output logic                       overflow_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [127:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_next;
  logic          full_q;
  logic          empty_q;
  logic          overflow_q;
  logic [1:0]    widx;

  logic          xfer;
  logic          pop;
  logic          do_write;
  logic          drop;
  logic [127:0]  head;
  logic [31:0]   head_word;

  assign word_valid_out = !empty_q && sm4_enable_in;
  assign xfer           = word_valid_out && word_ready_in;
  assign pop            = xfer && (widx == 2'd3);
  assign do_write       = sm4_enable_in && blk_valid_in && ((count_q < FULL_CNT) || pop);
  assign drop           = sm4_enable_in && blk_valid_in && (count_q == FULL_CNT) && !pop;

  assign head = mem[rptr];

  always_comb begin
    head_word = head[127:96];
    case (widx)
      2'd0: head_word = head[127:96];
      2'd1: head_word = head[95:64];
      2'd2: head_word = head[63:32];
      2'd3: head_word = head[31:0];
      default: head_word = head[127:96];
    endcase
  end

  assign word_data_out  = word_valid_out ? head_word : 32'h0;
  assign word_last_out  = word_valid_out && (widx == 2'd3);
  assign fifo_count_out = count_q;
  assign full_out       = full_q;
  assign empty_out      = empty_q;
  assign overflow_out   = overflow_q;

  always_comb begin
    count_next = count_q;
    if (do_write && !pop)
      count_next = count_q + 1'b1;
    else if (pop && !do_write)
      count_next = count_q - 1'b1;
  end

  // Storage array carries no reset; entries are only read once count covers them.
  always_ff @(posedge clk) begin
    if (do_write)
      mem[wptr] <= blk_data_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr       <= '0;
      rptr       <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      widx       <= 2'd0;
    end else if (!sm4_enable_in) begin
      wptr       <= '0;
      rptr       <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      widx       <= 2'd0;
    end else begin
      if (do_write)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      // widx is two bits wide, so the pop cycle wraps it back to word 0.
      if (xfer)
        widx <= widx + 2'd1;
      count_q <= count_next;
      full_q  <= (count_next == FULL_CNT);
      empty_q <= (count_next == '0);
      if (drop)
        overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sm4_result_serializer.sv
// Self-checking bench for sm4_result_serializer: a table of per-cycle vectors
// plus hand-written sequences for fill/overflow, full+pop, wrap, flush and reset.
module tb_sm4_result_serializer;

  logic         clk;
  logic         reset_n;
  logic         sm4_enable_in;
  logic         blk_valid_in;
  logic [127:0] blk_data_in;
  logic         word_ready_in;
  logic         word_valid_out;
  logic [31:0]  word_data_out;
  logic         word_last_out;
  logic [2:0]   fifo_count_out;
  logic         full_out;
  logic         empty_out;
  logic         overflow_out;

  int total_checks = 0;
  int pass_checks  = 0;

  sm4_result_serializer #(.DEPTH(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .sm4_enable_in  (sm4_enable_in),
    .blk_valid_in   (blk_valid_in),
    .blk_data_in    (blk_data_in),
    .word_ready_in  (word_ready_in),
    .word_valid_out (word_valid_out),
    .word_data_out  (word_data_out),
    .word_last_out  (word_last_out),
    .fifo_count_out (fifo_count_out),
    .full_out       (full_out),
    .empty_out      (empty_out),
    .overflow_out   (overflow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         en;
    logic         bv;
    logic [127:0] bd;
    logic         rdy;
    logic         exp_valid;
    logic [31:0]  exp_data;
    logic         exp_last;
    logic [2:0]   exp_count;
    logic         exp_empty;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs [15];

  localparam logic [127:0] BLK_A = 128'h681edf34d206965e86b3e94f536e4246;
  localparam logic [127:0] BLK_B = 128'h00112233445566778899aabbccddeeff;

  function automatic logic [31:0] word_of(input int k, input int w);
    return {8'hA5, 8'(k), 8'(w), 8'h5A};
  endfunction

  function automatic logic [127:0] blk(input int k);
    return {word_of(k, 0), word_of(k, 1), word_of(k, 2), word_of(k, 3)};
  endfunction

  task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
    total_checks++;
    if (actual === expected)
      pass_checks++;
    else
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic en, input logic bv, input logic [127:0] bd, input logic rdy);
    sm4_enable_in = en;
    blk_valid_in  = bv;
    blk_data_in   = bd;
    word_ready_in = rdy;
  endtask

  // Drains blocks first..last with ready held high, checking every word in order.
  task automatic expect_words(input int first, input int last);
    int b = first;
    int w = 0;
    int budget = (last - first + 1) * 4 + 20;
    apply_stimulus(1'b1, 1'b0, '0, 1'b1);
    while (b <= last && budget > 0) begin
      if (word_valid_out) begin
        check_output("drain_data", 128'(word_data_out), 128'(word_of(b, w)));
        check_output("drain_last", 128'(word_last_out), 128'(w == 3));
        if (w == 3) begin
          w = 0;
          b++;
        end else begin
          w++;
        end
      end
      step();
      budget--;
    end
    if (b <= last) begin
      total_checks++;
      $display("[TB] FAIL drain_timeout: stopped at block %0d, expected through %0d", b, last);
    end
  endtask

  initial begin
    int words_seen;
    int max_count;

    vecs[0]  = '{1'b1, 1'b1, BLK_A, 1'b1, 1'b0, 32'h0,        1'b0, 3'd0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, '0,    1'b1, 1'b1, 32'h681edf34, 1'b0, 3'd1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, '0,    1'b1, 1'b1, 32'hd206965e, 1'b0, 3'd1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, '0,    1'b1, 1'b1, 32'h86b3e94f, 1'b0, 3'd1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, '0,    1'b1, 1'b1, 32'h536e4246, 1'b1, 3'd1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, BLK_B, 1'b1, 1'b0, 32'h0,        1'b0, 3'd0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, '0,    1'b1, 1'b1, 32'h00112233, 1'b0, 3'd1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, '0,    1'b0, 1'b1, 32'h44556677, 1'b0, 3'd1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, '0,    1'b0, 1'b1, 32'h44556677, 1'b0, 3'd1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, '0,    1'b1, 1'b1, 32'h44556677, 1'b0, 3'd1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, '0,    1'b0, 1'b1, 32'h8899aabb, 1'b0, 3'd1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, '0,    1'b1, 1'b1, 32'h8899aabb, 1'b0, 3'd1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, '0,    1'b0, 1'b1, 32'hccddeeff, 1'b1, 3'd1, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, '0,    1'b1, 1'b1, 32'hccddeeff, 1'b1, 3'd1, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, '0,    1'b1, 1'b0, 32'h0,        1'b0, 3'd0, 1'b1, 1'b0};

    reset_n = 1'b0;
    apply_stimulus(1'b1, 1'b0, '0, 1'b0);
    step();
    step();
    check_output("rst_valid", 128'(word_valid_out), 128'(0));
    check_output("rst_data", 128'(word_data_out), 128'(0));
    check_output("rst_count", 128'(fifo_count_out), 128'(0));
    check_output("rst_empty", 128'(empty_out), 128'(1));
    check_output("rst_full", 128'(full_out), 128'(0));
    check_output("rst_ovf", 128'(overflow_out), 128'(0));
    reset_n = 1'b1;
    step();

    // Basic block and back-pressure, one vector per cycle.
    for (int i = 0; i < 15; i++) begin
      apply_stimulus(vecs[i].en, vecs[i].bv, vecs[i].bd, vecs[i].rdy);
      #1;
      check_output($sformatf("vec%0d_valid", i), 128'(word_valid_out), 128'(vecs[i].exp_valid));
      check_output($sformatf("vec%0d_data", i),  128'(word_data_out),  128'(vecs[i].exp_data));
      check_output($sformatf("vec%0d_last", i),  128'(word_last_out),  128'(vecs[i].exp_last));
      check_output($sformatf("vec%0d_count", i), 128'(fifo_count_out), 128'(vecs[i].exp_count));
      check_output($sformatf("vec%0d_empty", i), 128'(empty_out),      128'(vecs[i].exp_empty));
      check_output($sformatf("vec%0d_ovf", i),   128'(overflow_out),   128'(vecs[i].exp_ovf));
      step();
    end

    // Fill and overflow with ready low.
    for (int i = 1; i <= 5; i++) begin
      apply_stimulus(1'b1, 1'b1, blk(i), 1'b0);
      step();
      if (i == 4) begin
        check_output("fill4_full", 128'(full_out), 128'(1));
        check_output("fill4_ovf", 128'(overflow_out), 128'(0));
      end
    end
    apply_stimulus(1'b1, 1'b0, '0, 1'b0);
    #1;
    check_output("ovf_count", 128'(fifo_count_out), 128'(4));
    check_output("ovf_full", 128'(full_out), 128'(1));
    check_output("ovf_flag", 128'(overflow_out), 128'(1));
    check_output("ovf_head", 128'(word_data_out), 128'(word_of(1, 0)));
    expect_words(1, 4);
    check_output("ovf_no_blk5", 128'(word_valid_out), 128'(0));
    check_output("ovf_empty", 128'(empty_out), 128'(1));
    check_output("ovf_sticky", 128'(overflow_out), 128'(1));

    // Flush mid-block clears state and the sticky flag.
    apply_stimulus(1'b1, 1'b1, blk(7), 1'b1);
    step();
    apply_stimulus(1'b1, 1'b0, '0, 1'b1);
    step();
    step();
    check_output("flush_pre_word2", 128'(word_data_out), 128'(word_of(7, 2)));
    sm4_enable_in = 1'b0;
    #1;
    check_output("flush_valid_comb", 128'(word_valid_out), 128'(0));
    check_output("flush_data_comb", 128'(word_data_out), 128'(0));
    step();
    check_output("flush_count", 128'(fifo_count_out), 128'(0));
    check_output("flush_ovf", 128'(overflow_out), 128'(0));
    check_output("flush_empty", 128'(empty_out), 128'(1));
    apply_stimulus(1'b1, 1'b1, blk(8), 1'b0);
    step();
    apply_stimulus(1'b1, 1'b0, '0, 1'b0);
    #1;
    check_output("flush_widx_reset", 128'(word_data_out), 128'(word_of(8, 0)));
    sm4_enable_in = 1'b0;
    step();
    sm4_enable_in = 1'b1;

    // Full FIFO with a strobe on the last-word transfer.
    for (int i = 10; i <= 13; i++) begin
      apply_stimulus(1'b1, 1'b1, blk(i), 1'b0);
      step();
    end
    apply_stimulus(1'b1, 1'b0, '0, 1'b1);
    check_output("fp_full", 128'(full_out), 128'(1));
    for (int w = 0; w < 3; w++) begin
      check_output("fp_word", 128'(word_data_out), 128'(word_of(10, w)));
      step();
    end
    check_output("fp_last", 128'(word_last_out), 128'(1));
    apply_stimulus(1'b1, 1'b1, blk(14), 1'b1);
    step();
    apply_stimulus(1'b1, 1'b0, '0, 1'b1);
    check_output("fp_count", 128'(fifo_count_out), 128'(4));
    check_output("fp_full_after", 128'(full_out), 128'(1));
    check_output("fp_ovf", 128'(overflow_out), 128'(0));
    expect_words(11, 14);
    check_output("fp_empty", 128'(empty_out), 128'(1));

    // Pointer wrap: 10 blocks strobed every 4 cycles, ready high.
    words_seen = 0;
    max_count  = 0;
    for (int t = 0; t < 48; t++) begin
      apply_stimulus(1'b1, (t % 4 == 0) && (t < 40), blk(20 + t / 4), 1'b1);
      if (int'(fifo_count_out) > max_count)
        max_count = int'(fifo_count_out);
      if (word_valid_out && words_seen < 40) begin
        check_output("wrap_data", 128'(word_data_out), 128'(word_of(20 + words_seen / 4, words_seen % 4)));
        words_seen++;
      end
      step();
    end
    check_output("wrap_words", 128'(words_seen), 128'(40));
    check_output("wrap_maxcount_le2", 128'(max_count <= 2), 128'(1));

    // Asynchronous reset mid-stream.
    apply_stimulus(1'b1, 1'b1, blk(30), 1'b0);
    step();
    apply_stimulus(1'b1, 1'b1, blk(31), 1'b0);
    step();
    apply_stimulus(1'b1, 1'b0, '0, 1'b0);
    check_output("ar_pre_valid", 128'(word_valid_out), 128'(1));
    #2;
    reset_n = 1'b0;
    #1;
    check_output("ar_valid", 128'(word_valid_out), 128'(0));
    check_output("ar_data", 128'(word_data_out), 128'(0));
    check_output("ar_last", 128'(word_last_out), 128'(0));
    check_output("ar_count", 128'(fifo_count_out), 128'(0));
    check_output("ar_full", 128'(full_out), 128'(0));
    check_output("ar_empty", 128'(empty_out), 128'(1));
    check_output("ar_ovf", 128'(overflow_out), 128'(0));
    step();
    reset_n = 1'b1;
    apply_stimulus(1'b1, 1'b1, blk(40), 1'b1);
    step();
    apply_stimulus(1'b1, 1'b0, '0, 1'b1);
    check_output("ar_after_word0", 128'(word_data_out), 128'(word_of(40, 0)));
    step();

    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule
